// File: rtl/fp_pkg.sv
// Shared types, flag indices and rounding helper for the floating-point multiplier.
package fp_pkg;

  typedef enum logic [2:0] {FP_ZERO, FP_NORM, FP_INF, FP_QNAN, FP_SNAN} fp_class_e;

  // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  function automatic logic rne_round_up(input logic l, input logic g, input logic r, input logic s);
    return g & (r | s | l);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack and classification of one operand; denormals are treated as zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       man,
  output fp_class_e            cls
);

  logic [MAN_W-1:0] frac;

  assign sign = op[EXP_W+MAN_W];
  assign expo = op[EXP_W+MAN_W-1:MAN_W];
  assign frac = op[MAN_W-1:0];
  assign man  = {1'b1, frac};

  always_comb begin
    cls = FP_NORM;
    if (expo == '0) begin
      cls = FP_ZERO;
    end else if (expo == '1) begin
      if (frac == '0)
        cls = FP_INF;
      else if (frac[MAN_W-1])
        cls = FP_QNAN;
      else
        cls = FP_SNAN;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (classify, multiply, normalize/round)
// with valid/ready flow control, sideband tag and IEEE-style exception flags.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_p,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EMAX_S = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] ZERO_S = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: each stage moves when it is empty or the next stage moves
  logic v1_reg, v2_reg, out_valid_reg;
  logic adv1, adv2, adv3;

  assign adv3     = ~out_valid_reg | out_ready;
  assign adv2     = ~v2_reg | adv3;
  assign adv1     = ~v1_reg | adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      if (adv1) v1_reg <= in_valid;
      if (adv2) v2_reg <= v1_reg;
    end
  end

  // Stage 1: unpack, classify, resolve specials, add exponents
  logic [W-1:0]     op   [2];
  logic             sgn  [2];
  logic [EXP_W-1:0] ex   [2];
  logic [MAN_W:0]   man  [2];
  fp_class_e        cls  [2];

  assign op[0] = in_a;
  assign op[1] = in_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
      fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls (
        .op   (op[gi]),
        .sign (sgn[gi]),
        .expo (ex[gi]),
        .man  (man[gi]),
        .cls  (cls[gi])
      );
    end
  endgenerate

  logic                 any_nan, any_snan, any_inf, any_zero;
  logic                 s1_sign, s1_spec;
  logic [W-1:0]         s1_p;
  logic [3:0]           s1_f;
  logic signed [EW-1:0] s1_exp;

  always_comb begin
    any_snan = (cls[0] == FP_SNAN) || (cls[1] == FP_SNAN);
    any_nan  = any_snan || (cls[0] == FP_QNAN) || (cls[1] == FP_QNAN);
    any_inf  = (cls[0] == FP_INF) || (cls[1] == FP_INF);
    any_zero = (cls[0] == FP_ZERO) || (cls[1] == FP_ZERO);
    s1_sign  = sgn[0] ^ sgn[1];
    s1_exp   = $signed({2'b00, ex[0]}) + $signed({2'b00, ex[1]}) - BIAS_S;
    s1_spec  = 1'b1;
    s1_p     = '0;
    s1_f     = '0;
    if (any_nan || (any_inf && any_zero)) begin
      s1_p         = QNAN;
      s1_f[FLG_NV] = any_snan || (any_inf && any_zero);
    end else if (any_inf) begin
      s1_p = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      s1_p = {s1_sign, {(W-1){1'b0}}};
    end else begin
      s1_spec = 1'b0;
    end
  end

  logic                 sign1_reg, spec1_reg;
  logic signed [EW-1:0] exp1_reg;
  logic [MAN_W:0]       ma1_reg, mb1_reg;
  logic [W-1:0]         sp1_reg;
  logic [3:0]           sf1_reg;
  logic [TAG_W-1:0]     tag1_reg;

  always_ff @(posedge clk) begin
    if (adv1) begin
      sign1_reg <= s1_sign;
      exp1_reg  <= s1_exp;
      ma1_reg   <= man[0];
      mb1_reg   <= man[1];
      spec1_reg <= s1_spec;
      sp1_reg   <= s1_p;
      sf1_reg   <= s1_f;
      tag1_reg  <= in_tag;
    end
  end

  // Stage 2: full-width mantissa product
  logic                 sign2_reg, spec2_reg;
  logic signed [EW-1:0] exp2_reg;
  logic [PW-1:0]        prod2_reg;
  logic [W-1:0]         sp2_reg;
  logic [3:0]           sf2_reg;
  logic [TAG_W-1:0]     tag2_reg;

  always_ff @(posedge clk) begin
    if (adv2) begin
      sign2_reg <= sign1_reg;
      exp2_reg  <= exp1_reg;
      prod2_reg <= {{(MAN_W+1){1'b0}}, ma1_reg} * {{(MAN_W+1){1'b0}}, mb1_reg};
      spec2_reg <= spec1_reg;
      sp2_reg   <= sp1_reg;
      sf2_reg   <= sf1_reg;
      tag2_reg  <= tag1_reg;
    end
  end

  // Stage 3: normalize (hidden bit dropped), round to nearest even, range check
  logic [2*MAN_W:0]     norm3;
  logic [MAN_W-1:0]     frac3;
  logic                 g3, r3, s3, up3;
  logic [MAN_W:0]       frac_rnd3;
  logic signed [EW-1:0] e_norm3, e_fin3;
  logic [W-1:0]         p3;
  logic [3:0]           f3;

  always_comb begin
    norm3     = prod2_reg[PW-1] ? prod2_reg[PW-2:0] : {prod2_reg[PW-3:0], 1'b0};
    frac3     = norm3[2*MAN_W:MAN_W+1];
    g3        = norm3[MAN_W];
    r3        = norm3[MAN_W-1];
    s3        = |norm3[MAN_W-2:0];
    up3       = rne_round_up(frac3[0], g3, r3, s3);
    frac_rnd3 = {1'b0, frac3} + {{MAN_W{1'b0}}, up3};
    e_norm3   = exp2_reg + $signed({{(EW-1){1'b0}}, prod2_reg[PW-1]});
    // A fraction carry-out means the mantissa became exactly 2.0: bump exponent
    e_fin3    = e_norm3 + $signed({{(EW-1){1'b0}}, frac_rnd3[MAN_W]});
    p3        = {sign2_reg, e_fin3[EXP_W-1:0], frac_rnd3[MAN_W-1:0]};
    f3        = '0;
    f3[FLG_NX] = g3 | r3 | s3;
    if (spec2_reg) begin
      p3 = sp2_reg;
      f3 = sf2_reg;
    end else if (e_fin3 >= EMAX_S) begin
      p3         = {sign2_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f3[FLG_OF] = 1'b1;
      f3[FLG_NX] = 1'b1;
    end else if (e_fin3 <= ZERO_S) begin
      p3         = {sign2_reg, {(W-1){1'b0}}};
      f3[FLG_UF] = 1'b1;
      f3[FLG_NX] = 1'b1;
    end
  end

  logic [W-1:0]     out_p_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic [3:0]       out_flags_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_p_reg     <= '0;
      out_tag_reg   <= '0;
      out_flags_reg <= '0;
    end else if (adv3) begin
      out_valid_reg <= v2_reg;
      if (v2_reg) begin
        out_p_reg     <= p3;
        out_tag_reg   <= tag2_reg;
        out_flags_reg <= f3;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_p     = out_p_reg;
  assign out_tag   = out_tag_reg;
  assign out_flags = out_flags_reg;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe in FP32, BF16 and FP16 configurations.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // FP32 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_p;
  logic [3:0]  in_tag, out_tag, out_flags;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag), .out_flags(out_flags)
  );

  // BF16 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_a, b_in_b, b_out_p;
  logic [3:0]  b_in_tag, b_out_tag, b_out_flags;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut_bf16 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_p(b_out_p), .out_tag(b_out_tag), .out_flags(b_out_flags)
  );

  // FP16 instance
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_p;
  logic [3:0]  h_in_tag, h_out_tag, h_out_flags;

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_fp16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_tag(h_in_tag), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_p(h_out_p), .out_tag(h_out_tag), .out_flags(h_out_flags)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] p;
    logic [3:0]  f;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] stream_a [8];
  logic [31:0] exp_q [$];
  logic [3:0]  tag_q [$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic run32(input vec_t v);
    int n;
    @(negedge clk);
    in_a = v.a; in_b = v.b; in_tag = v.tag; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd3);
    chk("p", out_p, v.p);
    chk("tag", 32'(out_tag), 32'(v.tag));
    chk("flags", 32'(out_flags), 32'(v.f));
    $display("txn fp32 a=%h b=%h tag=%0d -> p=%h flags=%b lat=%0d", v.a, v.b, v.tag, out_p, out_flags, n);
  endtask

  task automatic run16(input bit bf, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] p_req, input logic [3:0] f_req);
    int n;
    logic ov;
    @(negedge clk);
    if (bf) begin
      b_in_a = a; b_in_b = b; b_in_tag = 4'd9; b_in_valid = 1'b1;
    end else begin
      h_in_a = a; h_in_b = b; h_in_tag = 4'd9; h_in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    h_in_valid = 1'b0;
    n = 1;
    ov = bf ? b_out_valid : h_out_valid;
    while (!ov && n < 10) begin
      @(negedge clk);
      n++;
      ov = bf ? b_out_valid : h_out_valid;
    end
    chk(bf ? "bf16_latency" : "fp16_latency", 32'(n), 32'd3);
    chk(bf ? "bf16_p" : "fp16_p", 32'(bf ? b_out_p : h_out_p), 32'(p_req));
    chk(bf ? "bf16_flags" : "fp16_flags", 32'(bf ? b_out_flags : h_out_flags), 32'(f_req));
    chk(bf ? "bf16_tag" : "fp16_tag", 32'(bf ? b_out_tag : h_out_tag), 32'd9);
    $display("txn %s a=%h b=%h -> p=%h flags=%b", bf ? "bf16" : "fp16", a, b,
             bf ? b_out_p : h_out_p, bf ? b_out_flags : h_out_flags);
  endtask

  initial begin
    int          sent, rcvd, cyc;
    bit          stalled;
    logic [31:0] held_p;
    logic [3:0]  held_tag, held_f;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 4'd5,  32'h40400000, 4'b0000}; // 1.5*2
    vecs[1]  = '{32'h3F800001, 32'h3F800001, 4'd1,  32'h3F800002, 4'b0001}; // sticky only
    vecs[2]  = '{32'h7F7FFFFF, 32'h40000000, 4'd2,  32'h7F800000, 4'b0101}; // overflow
    vecs[3]  = '{32'h7F800000, 32'h00000000, 4'd3,  32'h7FC00000, 4'b1000}; // inf*0
    vecs[4]  = '{32'h00800000, 32'h3F000000, 4'd4,  32'h00000000, 4'b0011}; // underflow
    vecs[5]  = '{32'h80000000, 32'h3F800000, 4'd6,  32'h80000000, 4'b0000}; // -0*1
    vecs[6]  = '{32'h7F800001, 32'h3F800000, 4'd7,  32'h7FC00000, 4'b1000}; // sNaN
    vecs[7]  = '{32'h7FC00001, 32'h3F800000, 4'd8,  32'h7FC00000, 4'b0000}; // qNaN
    vecs[8]  = '{32'hFF800000, 32'h40000000, 4'd9,  32'hFF800000, 4'b0000}; // -inf*2
    vecs[9]  = '{32'h00000001, 32'h7F000000, 4'd10, 32'h00000000, 4'b0000}; // denormal as zero
    vecs[10] = '{32'hBFC00000, 32'h40000000, 4'd11, 32'hC0400000, 4'b0000}; // -1.5*2
    vecs[11] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 4'd12, 32'h407FFFFE, 4'b0001}; // MSB set, round down
    vecs[12] = '{32'h3FFFFFFE, 32'h3F800001, 4'd13, 32'h40000000, 4'b0001}; // round carry-out
    vecs[13] = '{32'h7F7FFFFE, 32'h3F800001, 4'd14, 32'h7F800000, 4'b0101}; // overflow after round
    vecs[14] = '{32'h7F7FFFFF, 32'h3F800000, 4'd15, 32'h7F7FFFFF, 4'b0000}; // max finite
    vecs[15] = '{32'h00800000, 32'h3F800000, 4'd0,  32'h00800000, 4'b0000}; // min normal

    stream_a[0] = 32'h3F800000; stream_a[1] = 32'h40000000;
    stream_a[2] = 32'h40400000; stream_a[3] = 32'h40800000;
    stream_a[4] = 32'h40A00000; stream_a[5] = 32'h40C00000;
    stream_a[6] = 32'h40E00000; stream_a[7] = 32'h41000000;

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_tag = '0; b_out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_tag = '0; h_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", out_p, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) run32(vecs[i]);

    // Back-to-back stream of x*2.0 with out_ready toggling every cycle
    @(negedge clk);
    sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0;
    held_p = '0; held_tag = '0; held_f = '0;
    while (rcvd < 8 && cyc < 200) begin
      if (cyc != 0) @(negedge clk);
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_p", out_p, held_p);
        chk("hold_tag", 32'(out_tag), 32'(held_tag));
        chk("hold_flags", 32'(out_flags), 32'(held_f));
      end
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a = stream_a[sent]; in_b = 32'h40000000; in_tag = sent[3:0];
      end
      #1;
      stalled = out_valid && !out_ready;
      if (stalled) begin
        held_p = out_p; held_tag = out_tag; held_f = out_flags;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra_result", 32'(out_tag), 32'hFFFFFFFF);
        end else begin
          chk("bp_p", out_p, exp_q.pop_front());
          chk("bp_tag", 32'(out_tag), 32'(tag_q.pop_front()));
          chk("bp_flags", 32'(out_flags), 32'd0);
        end
        $display("txn stream tag=%0d p=%h cyc=%0d", out_tag, out_p, cyc);
        rcvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(stream_a[sent] + 32'h00800000);
        tag_q.push_back(sent[3:0]);
        sent++;
      end
      cyc++;
    end
    chk("bp_received", 32'(rcvd), 32'd8);
    chk("bp_sent", 32'(sent), 32'd8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_duplicate", 32'(out_valid), 32'd0);

    // Fill the pipeline under backpressure, then reset it
    out_ready = 1'b0;
    in_a = 32'h40400000; in_b = 32'h40400000; in_tag = 4'd7; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fill_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_p", out_p, 32'd0);
    chk("midrst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    $display("txn reset mid-stream done");
    run32(vecs[0]);

    run16(1'b1, 16'h3FC0, 16'h4000, 16'h4040, 4'b0000);
    run16(1'b1, 16'h3F81, 16'h3F81, 16'h3F82, 4'b0001);
    run16(1'b0, 16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
    run16(1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
